chacha_skid_pipeline: RTL and testbench

CHACHA_SKID_PIPELINE -- requirements
Module: chacha_skid_pipeline

---
 rtl/chacha_pkg.sv | 17 +
 rtl/chacha_skid_stage.sv | 88 ++++++++
 rtl/chacha_skid_pipeline.sv | 87 ++++++++
 tb/tb_chacha_skid_pipeline.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha skid pipeline: per-stage state encoding and occupancy width helper.
package chacha_pkg;

   // Encoding equals the number of words the stage holds, so it doubles as a count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   function automatic int occ_width(input int nb_stage);
      int w;
      w = $clog2(2 * nb_stage + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/chacha_skid_stage.sv
// One skid stage: main + skid register under an EMPTY/BUSY/FULL FSM, registered i_ready.
// o_count exposes the FSM state (equal to the words held) for debug and occupancy.
module chacha_skid_stage
   import chacha_pkg::*;
#(
   parameter int DATA_BUS_W = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [DATA_BUS_W-1:0] i_data,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_BUS_W-1:0] o_data,
   output logic [1:0]            o_count
);

   // Handshake: a word moves on a rising edge where valid and ready are both high;
   // valid never depends on ready, and i_ready is a flop so o_ready never reaches it combinationally.
   stage_state_e          state_q, state_d;
   logic [DATA_BUS_W-1:0] main_q, main_d;
   logic [DATA_BUS_W-1:0] skid_q, skid_d;
   logic                  rdy_q, rdy_d;
   logic                  take_in, take_out;

   assign take_in  = i_valid & rdy_q;
   assign take_out = (state_q != ST_EMPTY) & o_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (take_in) begin
               state_d = ST_BUSY;
               main_d  = i_data;
            end
         end
         ST_BUSY: begin
            if (take_in && !take_out) begin
               state_d = ST_FULL;
               skid_d  = i_data;
            end else if (!take_in && take_out) begin
               state_d = ST_EMPTY;
            end else if (take_in && take_out) begin
               main_d  = i_data;
            end
         end
         ST_FULL: begin
            if (take_out) begin
               state_d = ST_BUSY;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Synchronous clear wins over any transfer in the same cycle.
      if (srst) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
      rdy_d = (state_d != ST_FULL);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
      end
   end

   assign i_ready = rdy_q;
   assign o_valid = (state_q != ST_EMPTY);
   assign o_data  = main_q;
   assign o_count = state_q;

endmodule

// File: rtl/chacha_skid_pipeline.sv
// Cascade of NB_STAGE skid stages (NB_STAGE=0 is a wire-through).
// Define CHACHA_PIPE_OCC_EN to get a registered word count on o_occupancy; otherwise it is tied to 0.
module chacha_skid_pipeline
   import chacha_pkg::*;
#(
   parameter int  DATA_BUS_W = 8,
   parameter int  NB_STAGE   = 2,
   localparam int OCC_W      = occ_width(NB_STAGE)
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [DATA_BUS_W-1:0] i_data,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_BUS_W-1:0] o_data,
   output logic [OCC_W-1:0]      o_occupancy
);

   if (NB_STAGE == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl  = aclk ^ aresetn ^ srst;
      assign o_valid     = i_valid;
      assign o_data      = i_data;
      assign i_ready     = o_ready;
      assign o_occupancy = '0;
   end else begin : g_pipe
      logic                        vld [NB_STAGE+1];
      logic                        rdy [NB_STAGE+1];
      logic [DATA_BUS_W-1:0]       dat [NB_STAGE+1];
      logic [NB_STAGE-1:0][1:0]    cnt;
      logic                        unused_cnt;

      assign vld[0]        = i_valid;
      assign dat[0]        = i_data;
      assign i_ready       = rdy[0];
      assign o_valid       = vld[NB_STAGE];
      assign o_data        = dat[NB_STAGE];
      assign rdy[NB_STAGE] = o_ready;

      for (genvar k = 0; k < NB_STAGE; k++) begin : g_stage
         chacha_skid_stage #(
            .DATA_BUS_W (DATA_BUS_W)
         ) u_stage (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .i_valid (vld[k]),
            .i_ready (rdy[k]),
            .i_data  (dat[k]),
            .o_valid (vld[k+1]),
            .o_ready (rdy[k+1]),
            .o_data  (dat[k+1]),
            .o_count (cnt[k])
         );
      end

      // Per-stage counts are debug taps; the total below is tracked at the block boundary.
      assign unused_cnt = ^cnt;

`ifdef CHACHA_PIPE_OCC_EN
      // Internal hand-offs conserve words, so boundary in/out keeps the sum of stage counts.
      logic [OCC_W-1:0] occ_q, occ_d;
      logic             take_in, take_out;

      assign take_in  = i_valid & rdy[0];
      assign take_out = vld[NB_STAGE] & o_ready;

      always_comb begin
         occ_d = occ_q + OCC_W'(take_in) - OCC_W'(take_out);
         if (srst) occ_d = '0;
      end

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) occ_q <= '0;
         else          occ_q <= occ_d;
      end

      assign o_occupancy = occ_q;
`else
      assign o_occupancy = '0;
`endif
   end

endmodule

// File: tb/tb_chacha_skid_pipeline.sv
// Directed bench for chacha_skid_pipeline: reset, streaming, fill/drain, srst, NB_STAGE=0 and random traffic.
module tb_chacha_skid_pipeline;

`ifdef CHACHA_PIPE_OCC_EN
   localparam bit OCC_EN = 1'b1;
`else
   localparam bit OCC_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic aclk;
   logic aresetn;
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // ---------------- DUT signals ----------------
   // s_: NB_STAGE=2 streaming, f_: NB_STAGE=3 fill/drain/srst, z_: NB_STAGE=0, r_: NB_STAGE=2 x 32-bit random
   logic       s_srst, s_iv, s_ird, s_ov, s_ord;
   logic [7:0] s_id, s_od;
   logic [2:0] s_occ;
   logic       f_srst, f_iv, f_ird, f_ov, f_ord;
   logic [7:0] f_id, f_od;
   logic [2:0] f_occ;
   logic       z_srst, z_iv, z_ird, z_ov, z_ord;
   logic [7:0] z_id, z_od;
   logic [0:0] z_occ;
   logic        r_srst, r_iv, r_ird, r_ov, r_ord;
   logic [31:0] r_id, r_od;
   logic [2:0]  r_occ;

   chacha_skid_pipeline #(.DATA_BUS_W(8), .NB_STAGE(2)) u_s (
      .aclk(aclk), .aresetn(aresetn), .srst(s_srst),
      .i_valid(s_iv), .i_ready(s_ird), .i_data(s_id),
      .o_valid(s_ov), .o_ready(s_ord), .o_data(s_od), .o_occupancy(s_occ));

   chacha_skid_pipeline #(.DATA_BUS_W(8), .NB_STAGE(3)) u_f (
      .aclk(aclk), .aresetn(aresetn), .srst(f_srst),
      .i_valid(f_iv), .i_ready(f_ird), .i_data(f_id),
      .o_valid(f_ov), .o_ready(f_ord), .o_data(f_od), .o_occupancy(f_occ));

   chacha_skid_pipeline #(.DATA_BUS_W(8), .NB_STAGE(0)) u_z (
      .aclk(aclk), .aresetn(aresetn), .srst(z_srst),
      .i_valid(z_iv), .i_ready(z_ird), .i_data(z_id),
      .o_valid(z_ov), .o_ready(z_ord), .o_data(z_od), .o_occupancy(z_occ));

   chacha_skid_pipeline #(.DATA_BUS_W(32), .NB_STAGE(2)) u_r (
      .aclk(aclk), .aresetn(aresetn), .srst(r_srst),
      .i_valid(r_iv), .i_ready(r_ird), .i_data(r_id),
      .o_valid(r_ov), .o_ready(r_ord), .o_data(r_od), .o_occupancy(r_occ));

   // ---------------- scoreboard ----------------
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_occ(input int words);
      return OCC_EN ? words : 0;
   endfunction

   // ---------------- vector tables ----------------
   typedef struct {
      logic       iv;
      logic       ordy;
      logic [7:0] din;
      logic       e_ov;
      logic       e_irdy;
      logic [7:0] e_dat;
   } bp_vec_t;

   typedef struct {
      logic       iv;
      logic       ordy;
      logic [7:0] din;
      logic       e_irdy;
      logic       e_ov;
      logic [7:0] e_dat;
      int         e_occ;
   } fd_vec_t;

   bp_vec_t bp_tab [6];
   fd_vec_t fd_tab [15];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned sent, rcvd, cyc;
      logic [31:0] w;

      aresetn = 1'b0;
      s_srst = 0; s_iv = 0; s_ord = 0; s_id = '0;
      f_srst = 0; f_iv = 0; f_ord = 0; f_id = '0;
      z_srst = 0; z_iv = 0; z_ord = 0; z_id = '0;
      r_srst = 0; r_iv = 0; r_ord = 0; r_id = '0;

      // NB_STAGE=0: combinational pass-through, i_ready follows o_ready in the same cycle
      bp_tab[0] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C};
      bp_tab[1] = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C};
      bp_tab[2] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3};
      bp_tab[3] = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'hAA};
      bp_tab[4] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55};
      bp_tab[5] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF};

      // NB_STAGE=3: o_ready=0 fill (6 words absorbed), then drain with i_valid=0
      fd_tab[0]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 8'h00, 0};
      fd_tab[1]  = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b0, 8'h00, 1};
      fd_tab[2]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 8'h00, 2};
      fd_tab[3]  = '{1'b1, 1'b0, 8'hA4, 1'b1, 1'b1, 8'hA1, 3};
      fd_tab[4]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA1, 4};
      fd_tab[5]  = '{1'b1, 1'b0, 8'hA6, 1'b1, 1'b1, 8'hA1, 5};
      fd_tab[6]  = '{1'b1, 1'b0, 8'hA7, 1'b0, 1'b1, 8'hA1, 6};
      fd_tab[7]  = '{1'b1, 1'b0, 8'hA7, 1'b0, 1'b1, 8'hA1, 6};
      fd_tab[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA1, 6};
      fd_tab[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA2, 5};
      fd_tab[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA3, 4};
      fd_tab[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA4, 3};
      fd_tab[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 2};
      fd_tab[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA6, 1};
      fd_tab[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 0};

      // ---- reset state ----
      repeat (2) @(negedge aclk);
      #1;
      chk("rst_f_ovalid", 64'(f_ov), 64'(0));
      chk("rst_f_iready", 64'(f_ird), 64'(0));
      chk("rst_f_odata", 64'(f_od), 64'(0));
      chk("rst_f_occ", 64'(f_occ), 64'(0));
      chk("rst_s_iready", 64'(s_ird), 64'(0));
      chk("rst_r_ovalid", 64'(r_ov), 64'(0));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("rel_before_clk_iready", 64'(f_ird), 64'(0));

      // ---- streaming, NB_STAGE=2, words 0x01..0x10 back to back ----
      for (int k = 0; k < 20; k++) begin
         @(negedge aclk);
         s_iv  = (k < 16);
         s_id  = 8'(k + 1);
         s_ord = 1'b1;
         #1;
         chk("stream_iready", 64'(s_ird), 64'(1));
         chk("stream_ovalid", 64'(s_ov), 64'((k >= 2) && (k < 18)));
         if ((k >= 2) && (k < 18)) chk("stream_odata", 64'(s_od), 64'(k - 1));
         if (k == 8) chk("stream_occ_mid", 64'(s_occ), 64'(exp_occ(2)));
      end
      chk("stream_occ_end", 64'(s_occ), 64'(exp_occ(0)));

      // ---- NB_STAGE=0 table ----
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         z_iv  = bp_tab[i].iv;
         z_ord = bp_tab[i].ordy;
         z_id  = bp_tab[i].din;
         #1;
         chk("nb0_ovalid", 64'(z_ov), 64'(bp_tab[i].e_ov));
         chk("nb0_iready", 64'(z_ird), 64'(bp_tab[i].e_irdy));
         chk("nb0_odata", 64'(z_od), 64'(bp_tab[i].e_dat));
         chk("nb0_occ", 64'(z_occ), 64'(0));
      end

      // ---- fill / drain table, NB_STAGE=3 ----
      for (int i = 0; i < 15; i++) begin
         @(negedge aclk);
         f_iv  = fd_tab[i].iv;
         f_ord = fd_tab[i].ordy;
         f_id  = fd_tab[i].din;
         #1;
         chk("fd_iready", 64'(f_ird), 64'(fd_tab[i].e_irdy));
         chk("fd_ovalid", 64'(f_ov), 64'(fd_tab[i].e_ov));
         if (fd_tab[i].e_ov) chk("fd_odata", 64'(f_od), 64'(fd_tab[i].e_dat));
         chk("fd_occ", 64'(f_occ), 64'(exp_occ(fd_tab[i].e_occ)));
      end

      // ---- srst with 4 words held and an input transfer in the same cycle ----
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         f_iv = 1'b1; f_ord = 1'b0; f_id = 8'(8'hB1 + i);
         #1;
         chk("srst_fill_iready", 64'(f_ird), 64'(1));
      end
      @(negedge aclk);
      f_srst = 1'b1; f_iv = 1'b1; f_id = 8'h5A; f_ord = 1'b1;
      #1;
      chk("srst_pre_occ", 64'(f_occ), 64'(exp_occ(4)));
      chk("srst_pre_ovalid", 64'(f_ov), 64'(1));
      chk("srst_pre_odata", 64'(f_od), 64'(8'hB1));
      @(negedge aclk);
      f_srst = 1'b0; f_iv = 1'b0;
      #1;
      chk("srst_post_ovalid", 64'(f_ov), 64'(0));
      chk("srst_post_occ", 64'(f_occ), 64'(0));
      chk("srst_post_iready", 64'(f_ird), 64'(1));
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         #1;
         chk("srst_no_leak", 64'(f_ov), 64'(0));
      end
      @(negedge aclk);
      f_iv = 1'b1; f_id = 8'h77;
      @(negedge aclk);
      f_iv = 1'b0;
      #1;
      chk("srst_new_lat1", 64'(f_ov), 64'(0));
      @(negedge aclk);
      #1;
      chk("srst_new_lat2", 64'(f_ov), 64'(0));
      @(negedge aclk);
      #1;
      chk("srst_new_ovalid", 64'(f_ov), 64'(1));
      chk("srst_new_odata", 64'(f_od), 64'(8'h77));
      @(negedge aclk);
      #1;
      chk("srst_new_gone", 64'(f_ov), 64'(0));

      // ---- random traffic, NB_STAGE=2, 32-bit, 10000 words ----
      sent = 0; rcvd = 0; cyc = 0;
      while ((rcvd < 10000) && (cyc < 60000)) begin
         @(negedge aclk);
         cyc++;
         r_iv  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
         r_id  = $urandom;
         r_ord = 1'($urandom_range(0, 1));
         #1;
         if (r_iv && r_ird) begin
            exp_q.push_back(r_id);
            sent++;
         end
         if (r_ov && r_ord) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL rand_dup: got 0x%0h, expected no word", r_od);
            end else begin
               w = exp_q.pop_front();
               chk("rand_data", 64'(r_od), 64'(w));
            end
            rcvd++;
         end
      end
      chk("rand_count", 64'(rcvd), 64'(10000));
      chk("rand_q_empty", 64'(exp_q.size()), 64'(0));
      r_iv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         r_ord = 1'b1;
         #1;
         chk("rand_idle_ovalid", 64'(r_ov), 64'(0));
      end
      chk("rand_occ_end", 64'(r_occ), 64'(exp_occ(0)));

      // ---- asynchronous reset while holding a word ----
      @(negedge aclk);
      f_iv = 1'b1; f_id = 8'h99; f_ord = 1'b0;
      @(negedge aclk);
      f_iv = 1'b0;
      repeat (2) @(negedge aclk);
      #1;
      chk("arst_pre_ovalid", 64'(f_ov), 64'(1));
      chk("arst_pre_odata", 64'(f_od), 64'(8'h99));
      #1;
      aresetn = 1'b0;
      #1;
      chk("arst_ovalid", 64'(f_ov), 64'(0));
      chk("arst_odata", 64'(f_od), 64'(0));
      chk("arst_iready", 64'(f_ird), 64'(0));
      chk("arst_occ", 64'(f_occ), 64'(0));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("arst_rel_iready0", 64'(f_ird), 64'(0));
      @(negedge aclk);
      #1;
      chk("arst_rel_iready1", 64'(f_ird), 64'(1));
      chk("arst_rel_ovalid", 64'(f_ov), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
